// File: rtl/proc_run_ctrl_pkg.sv
// Shared types for the processor run controller: FSM states and register index.
package proc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } run_state_e;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/pc_halt_detector.sv
// Flags a halted program once the PC has repeated itself HALT_CYCLES times in a row.
module pc_halt_detector #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            halted
);

  localparam int unsigned SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0] HALT_LIM = SW'(HALT_CYCLES);

  logic [XLEN-1:0] prev_q, prev_d;
  logic [SW-1:0]   stable_q, stable_d;

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    if (clear) begin
      prev_d   = '0;
      stable_d = '0;
    end else if (en_i) begin
      prev_d = pc_i;
      if (pc_i == prev_q) begin
        if (stable_q != HALT_LIM) stable_d = stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
    end
  end

  // Registered count keeps the halt decision free of combinational PC paths.
  assign halted = (stable_q == HALT_LIM);

endmodule

// File: rtl/proc_run_controller.sv
// Run controller: holds the processor in reset, runs it, counts cycles/write-backs
// and judges pass/fail/timeout from PC self-loop and a signature register.
module proc_run_controller
  import proc_run_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 200,
  parameter int unsigned HALT_CYCLES  = 4,
  parameter int unsigned SIG_REG      = 10,
  parameter int unsigned PASS_VALUE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             wb_en,
  input  reg_idx_t         wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             proc_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [XLEN-1:0]  signature
);

  localparam int unsigned      HW       = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0]    HOLD_END = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
  localparam reg_idx_t         SIG_IDX  = 5'(SIG_REG);
  localparam logic [XLEN-1:0]  PASS_V   = XLEN'(PASS_VALUE);

  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] wbc_q, wbc_d;
  logic [XLEN-1:0]  sig_q, sig_d;
  logic             wr_q, wr_d;
  logic             det_clear, det_en, halted;

  pc_halt_detector #(
    .XLEN        (XLEN),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk    (clk),
    .rst    (reset),
    .clear  (det_clear),
    .en_i   (det_en),
    .pc_i   (pc_in),
    .halted (halted)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cyc_d     = cyc_q;
    wbc_d     = wbc_q;
    sig_d     = sig_q;
    wr_d      = wr_q;
    det_clear = 1'b0;
    det_en    = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_END) begin
          hold_d  = '0;
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        det_en = 1'b1;
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (wb_en && (wb_rd != '0) && (wbc_q != '1)) wbc_d = wbc_q + 1'b1;
        if (wb_en && (wb_rd == SIG_IDX) && (SIG_IDX != '0)) begin
          sig_d = wb_data;
          wr_d  = 1'b1;
        end
        // Verdict uses the next-state signature so a same-cycle write counts.
        if (halted) begin
          state_d = (wr_d && (sig_d == PASS_V)) ? ST_PASS : ST_FAIL;
        end else if (cyc_d == MAX_C) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          cyc_d     = '0;
          wbc_d     = '0;
          sig_d     = '0;
          wr_d      = 1'b0;
          det_clear = 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      cyc_q   <= '0;
      wbc_q   <= '0;
      sig_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      wbc_q   <= wbc_d;
      sig_q   <= sig_d;
      wr_q    <= wr_d;
    end
  end

  assign proc_reset  = (state_q == ST_HOLD);
  assign running     = (state_q == ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign done        = pass | fail | timeout;
  assign cycle_count = cyc_q;
  assign wb_count    = wbc_q;
  assign signature   = sig_q;

endmodule

// File: tb/tb_proc_run_controller.sv
// Randomized bench for proc_run_controller against a cycle-list reference model.
module tb_proc_run_controller;

  localparam int RST_C  = 3;
  localparam int MAX_C  = 20;
  localparam int HALT_C = 4;
  localparam int SIG_R  = 10;
  localparam int PASS_V = 1;

  logic        clk = 1'b0;
  logic        reset, start, wb_en;
  logic [31:0] pc_in, wb_data;
  logic [4:0]  wb_rd;
  logic        proc_reset, running, done, pass, fail, timeout;
  logic [31:0] cycle_count, wb_count, signature;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] pcs [1:40];
  logic        wen [1:40];
  logic [4:0]  rds [1:40];
  logic [31:0] dat [1:40];

  int          exp_n, exp_kind, exp_wb;
  logic [31:0] exp_sig;

  proc_run_controller #(
    .XLEN(32), .CNT_W(32), .RESET_CYCLES(RST_C), .MAX_CYCLES(MAX_C),
    .HALT_CYCLES(HALT_C), .SIG_REG(SIG_R), .PASS_VALUE(PASS_V)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .proc_reset(proc_reset), .running(running),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .wb_count(wb_count), .signature(signature)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_proc_reset"}, 32'(proc_reset), 1);
    check({tag, "_running"}, 32'(running), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_wb_count"}, wb_count, 0);
    check({tag, "_signature"}, signature, 0);
  endtask

  // mode 0: no x10 write (plus an x0 write), 1: x10<=1, 2: x10<=0, 3: random x10 traffic
  task automatic gen_prog(input int inc_len, input int mode);
    int j;
    for (int k = 1; k <= 40; k++) begin
      pcs[k] = (k <= inc_len) ? 32'(4 * (k - 1)) : 32'(4 * (inc_len - 1));
      wen[k] = 1'($urandom_range(0, 1));
      rds[k] = 5'($urandom_range(0, 31));
      dat[k] = $urandom;
      if (mode != 3 && rds[k] == 5'(SIG_R)) rds[k] = 5'(SIG_R + 1);
      if (mode == 3) begin
        if ($urandom_range(0, 3) == 0) rds[k] = 5'(SIG_R);
        dat[k] = 32'($urandom_range(0, 1));
      end
    end
    if (mode == 1 || mode == 2) begin
      j = int'($urandom_range(1, 3));
      wen[j] = 1'b1;
      rds[j] = 5'(SIG_R);
      dat[j] = (mode == 1) ? 32'(PASS_V) : 32'd0;
    end
    if (mode == 0) begin
      wen[2] = 1'b1;
      rds[2] = 5'd0;
    end
  endtask

  // Halt is declared on the cycle after the PC has matched its predecessor
  // HALT_C times running; budget ends after MAX_C cycles; halt wins a tie.
  task automatic model();
    int streak = 0;
    logic [31:0] prev = 0;
    logic wr = 0;
    exp_wb = 0; exp_sig = 0; exp_n = 0; exp_kind = -1;
    for (int n = 1; n <= MAX_C; n++) begin
      bit halt_now = (streak >= HALT_C);
      if (wen[n] && rds[n] != 0) exp_wb++;
      if (wen[n] && rds[n] == 5'(SIG_R)) begin exp_sig = dat[n]; wr = 1; end
      if (halt_now) begin
        exp_n = n; exp_kind = (wr && exp_sig == 32'(PASS_V)) ? 0 : 1; break;
      end
      if (n == MAX_C) begin exp_n = n; exp_kind = 2; break; end
      streak = (pcs[n] == prev) ? streak + 1 : 0;
      prev = pcs[n];
    end
  endtask

  task automatic wait_running(output int cnt);
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk);
      cnt++;
      if (running) break;
    end
  endtask

  task automatic drive_idle();
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic relaunch(input string tag);
    int hc;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_proc_reset"}, 32'(proc_reset), 1);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_wb_count"}, wb_count, 0);
    check({tag, "_signature"}, signature, 0);
    wait_running(hc);
    check({tag, "_hold_cycles"}, 32'(hc), 32'(RST_C));
  endtask

  task automatic run_and_check(input string tag);
    int got = 0;
    model();
    for (int k = 1; k <= 40; k++) begin
      pc_in = pcs[k]; wb_en = wen[k]; wb_rd = rds[k]; wb_data = dat[k];
      @(posedge clk);
      #1;
      if (done) begin got = k; break; end
      @(negedge clk);
    end
    @(negedge clk);
    drive_idle();
    check({tag, "_cycles_to_done"}, 32'(got), 32'(exp_n));
    check({tag, "_pass"}, 32'(pass), 32'(exp_kind == 0));
    check({tag, "_fail"}, 32'(fail), 32'(exp_kind == 1));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_kind == 2));
    check({tag, "_running"}, 32'(running), 0);
    check({tag, "_proc_reset"}, 32'(proc_reset), 0);
    check({tag, "_cycle_count"}, cycle_count, 32'(exp_n));
    check({tag, "_wb_count"}, wb_count, 32'(exp_wb));
    check({tag, "_signature"}, signature, exp_sig);
    for (int k = 0; k < 2; k++) begin
      pc_in = $urandom; wb_en = 1'b1; wb_rd = 5'(SIG_R); wb_data = $urandom;
      @(negedge clk);
    end
    drive_idle();
    check({tag, "_frozen_done"}, 32'(done), 1);
    check({tag, "_frozen_cycles"}, cycle_count, 32'(exp_n));
    check({tag, "_frozen_wb"}, wb_count, 32'(exp_wb));
    check({tag, "_frozen_sig"}, signature, exp_sig);
  endtask

  initial begin
    int hc;
    reset = 1'b1; start = 1'b0; pc_in = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    wait_running(hc);
    check("por_hold_cycles", 32'(hc), 32'(RST_C));

    gen_prog(4, 1);  run_and_check("halt_pass");
    relaunch("start1");
    gen_prog(4, 2);  run_and_check("halt_sig0");
    relaunch("start2");
    gen_prog(4, 0);  run_and_check("halt_nowrite");
    relaunch("start3");
    gen_prog(40, 3); run_and_check("timeout");
    relaunch("start4");
    gen_prog(15, 1); run_and_check("halt_at_max");

    // asynchronous reset in the middle of a run
    relaunch("start5");
    gen_prog(40, 3);
    for (int k = 1; k <= 5; k++) begin
      pc_in = pcs[k]; wb_en = wen[k]; wb_rd = rds[k]; wb_data = dat[k];
      @(negedge clk);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    wait_running(hc);
    check("midrun_hold_cycles", 32'(hc), 32'(RST_C));
    gen_prog(6, 3); run_and_check("after_reset");

    for (int r = 0; r < 8; r++) begin
      relaunch("rand_start");
      gen_prog(int'($urandom_range(1, 22)), int'($urandom_range(0, 3)));
      run_and_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/proc_run_controller.md
# proc_run_controller

- Parametrised, synthesisable run controller that replaces the fixed reset/run/finish sequencing of the processor testbench.
- Holds the processor in reset for a configurable number of cycles, then runs it and counts cycles and register write-backs.
- Detects program halt (PC self-loop), judges pass/fail from a signature register, and flags timeout.
- Sits between the clock/reset source and `RISC_V_Processor`, usable in simulation benches and on FPGA.

## Interface
Parameters:
- `XLEN`, 32: PC and write-back data width.
- `CNT_W`, 32: width of the cycle and write-back counters.
- `RESET_CYCLES`, 1: cycles `proc_reset` is held after entering HOLD; ≥1.
- `MAX_CYCLES`, 200: RUN-cycle budget before timeout; ≥1, < 2^CNT_W.
- `HALT_CYCLES`, 4: consecutive cycles of unchanged PC that mean halt; ≥1.
- `SIG_REG`, 10: destination register watched as the signature (a0).
- `PASS_VALUE`, 1: signature value meaning pass.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: pulse that re-launches a run from a DONE state.
- `pc_in`  in  XLEN: current processor PC.
- `wb_en`  in  1: register-file write enable.
- `wb_rd`  in  5: write destination register.
- `wb_data`  in  XLEN: write data.
- `proc_reset`  out  1: reset to the processor, active-high.
- `running`  out  1: high in RUN.
- `done`  out  1: high in PASS, FAIL and TIMEOUT.
- `pass`  out  1: halted with the signature equal to `PASS_VALUE`.
- `fail`  out  1: halted with a wrong or never-written signature.
- `timeout`  out  1: cycle budget exhausted.
- `cycle_count`  out  CNT_W: RUN cycles elapsed.
- `wb_count`  out  CNT_W: counted write-backs.
- `signature`  out  XLEN: last value written to `SIG_REG`.

## Operation
States: HOLD, RUN, PASS, FAIL, TIMEOUT.

While `reset` is high:
- State is HOLD and `proc_reset`=1.
- All counters, `signature`, the signature-written flag and the halt tracker are 0.
- `running`, `done`, `pass`, `fail` and `timeout` are 0.

HOLD:
- Hold counter increments each cycle.
- After `RESET_CYCLES` cycles in HOLD, go to RUN; `proc_reset` is 0 from the RUN entry cycle.
- `start` is ignored.

RUN:
- `cycle_count` +1 per cycle, saturating.
- Write-back is counted when `wb_en`=1 and `wb_rd`≠0; `wb_count` +1, saturating.
- When `wb_en`=1 and `wb_rd`=`SIG_REG` (and `SIG_REG`≠0): `signature`←`wb_data` and the written flag is set.
- Halt tracker: `prev_pc`←`pc_in` every cycle. Stable count +1 when `pc_in`==`prev_pc`, else cleared. The first RUN cycle compares against the reset `prev_pc` of 0.
- Halt when the stable count reaches `HALT_CYCLES`:
  - go to PASS if the written flag is set and `signature`==`PASS_VALUE`, including a write in the same cycle;
  - otherwise go to FAIL.
- Timeout when `cycle_count` reaches `MAX_CYCLES` → TIMEOUT.
- Halt and timeout in the same cycle: halt wins.
- `start` is ignored.

PASS, FAIL, TIMEOUT:
- Terminal states; counters and `signature` are frozen.
- `proc_reset` stays 0; the processor keeps running and is not observed.
- `start`=1 → HOLD: counters, `signature`, the written flag and the tracker are cleared, and `proc_reset`=1.

## Timing
- All outputs are registered and decoded from state and counters; no combinational input-to-output paths.
- `reset` deassertion: the first rising edge starts HOLD counting. With `RESET_CYCLES`=1, `proc_reset` falls after exactly 1 clock.
- Halt latency: the `done` edge comes `HALT_CYCLES` cycles after the first repeated PC, plus 1 registered cycle.
- `pass`, `fail` and `timeout` are one-hot, valid while `done`=1, and change in the same cycle as `done`.
- `start` is sampled on a rising edge; a one-cycle pulse suffices. A held `start` re-launches only once per DONE entry, because HOLD ignores it.
- `reset` mid-run asynchronously returns to HOLD with all outputs at reset values.

## Structure
- Package `proc_run_ctrl_pkg`: state enum (HOLD, RUN, PASS, FAIL, TIMEOUT) and the 5-bit register-index type.
- Sub-module `pc_halt_detector`: holds `prev_pc` and the stable counter, has parameters `XLEN`/`HALT_CYCLES`, and takes a `clear` input. It outputs `halted`.
- Top level holds the FSM, counters and signature capture.
- `tb_RISC_V_Processor` is rewritten to instantiate this block and `$finish` on `done`.

## Test plan
- Reset release, `RESET_CYCLES`=3 → `proc_reset` high for exactly 3 cycles after deassert, `running` rises on the 4th.
- Drive the PC 0,4,8,12 then hold 12 with a prior write `wb_rd`=10, `wb_data`=1, and `HALT_CYCLES`=4 → `done`=`pass`=1. `cycle_count` is frozen, `signature`=1 and `wb_count`=1.
- Same halt, but with signature 0 or no write to x10 → `fail`=1, `pass`=0. A `wb_rd`=0 write is not counted.
- Incrementing PC with `MAX_CYCLES`=20 → `timeout`=1 and `done`=1 with `cycle_count`=20. With PC stable so halt lands on cycle 20 exactly → PASS or FAIL, not TIMEOUT.
- In PASS, pulse `start` → HOLD with `proc_reset`=1 and counters 0, then a second run completes normally.
- Assert `reset` asynchronously mid-RUN → all outputs drop to reset values without waiting for a clock edge, then the sequence restarts cleanly.
